// File: rtl/match_window_counter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// match_window_counter
//
// Counts match pulses from a "101" sequence detector over fixed windows of
// WINDOW qualified bits. Each completed window's count is presented on a
// valid/ready output slot along with a wrapping 4-bit sequence number. If a
// window completes while the slot is still occupied, that result is discarded
// and the sticky drop_err flag is raised.
//
// Parameters
//   WINDOW : qualified bits per window, 2..255
//   CNT_W  : width of the count; the count saturates at 2^CNT_W-1
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   en         in   enable counting; dropping it aborts the partial window
//   bit_valid  in   qualifies one detector bit this cycle
//   match_in   in   detector match output, sampled only with bit_valid=1
//   cnt_out    out  window match count (CNT_W bits)
//   cnt_valid  out  cnt_out/seq_no hold a result
//   cnt_ready  in   consumer accepts the result when cnt_valid=1
//   seq_no     out  window sequence number, wraps 15->0
//   drop_err   out  sticky flag: a completed window was discarded
//   clr_err    in   synchronous clear of drop_err (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module match_window_counter #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             bit_valid,
  input  logic             match_in,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic [3:0]       seq_no,
  output logic             drop_err,
  input  logic             clr_err
);

  localparam int                POS_W    = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [POS_W-1:0]  LAST_POS = POS_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  // Add a single match to an accumulator, holding at full scale instead of
  // wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a,
                                               input logic             inc);
    logic [CNT_W-1:0] r;
    r = a;
    if (inc && (a != CNT_MAX)) begin
      r = a + CNT_W'(1);
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [3:0]       seq_cnt_q, seq_cnt_d;
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
  logic [3:0]       seq_no_q, seq_no_d;
  logic             cnt_valid_q, cnt_valid_d;
  logic             drop_err_q, drop_err_d;

  // FSM decoded controls
  logic counting;
  logic aborting;

  // Datapath controls
  logic             take_bit;
  logic             final_bit;
  logic             slot_free;
  logic             load_slot;
  logic             drop_slot;
  logic [CNT_W-1:0] acc_sum;
  logic [3:0]       seq_next;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en)  state_d = COUNT;
      COUNT:   if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: decoded outputs. The IDLE->COUNT transition cycle is not "counting",
  // so a bit presented while entering COUNT is ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    counting = 1'b0;
    aborting = 1'b0;
    unique case (state_q)
      IDLE: begin
        counting = 1'b0;
        aborting = 1'b0;
      end
      COUNT: begin
        counting = en;
        aborting = !en;
      end
      default: begin
        counting = 1'b0;
        aborting = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Window accumulation and output slot control
  // ---------------------------------------------------------------------------
  always_comb begin
    take_bit  = counting && bit_valid;
    final_bit = take_bit && (pos_q == LAST_POS);
    acc_sum   = sat_inc(acc_q, match_in);
    seq_next  = seq_cnt_q + 4'd1;

    // The slot can take a new result when empty or when being emptied by an
    // acceptance in this very cycle.
    slot_free = !cnt_valid_q || cnt_ready;
    load_slot = final_bit && slot_free;
    drop_slot = final_bit && !slot_free;

    pos_d = pos_q;
    acc_d = acc_q;
    if (aborting || final_bit) begin
      pos_d = '0;
      acc_d = '0;
    end else if (take_bit) begin
      pos_d = pos_q + POS_W'(1);
      acc_d = acc_sum;
    end

    // The internal window counter advances on every completed window, dropped
    // or not, so a consumer sees a gap in seq_no after a drop.
    seq_cnt_d = final_bit ? seq_next : seq_cnt_q;

    cnt_out_d   = cnt_out_q;
    seq_no_d    = seq_no_q;
    cnt_valid_d = cnt_valid_q;
    if (load_slot) begin
      cnt_out_d   = acc_sum;
      seq_no_d    = seq_next;
      cnt_valid_d = 1'b1;
    end else if (cnt_valid_q && cnt_ready) begin
      cnt_valid_d = 1'b0;
    end

    drop_err_d = drop_err_q;
    if (drop_slot) begin
      drop_err_d = 1'b1;
    end else if (clr_err) begin
      drop_err_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered window state and output slot
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_q       <= '0;
      acc_q       <= '0;
      seq_cnt_q   <= '0;
      cnt_out_q   <= '0;
      seq_no_q    <= '0;
      cnt_valid_q <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      acc_q       <= acc_d;
      seq_cnt_q   <= seq_cnt_d;
      cnt_out_q   <= cnt_out_d;
      seq_no_q    <= seq_no_d;
      cnt_valid_q <= cnt_valid_d;
      drop_err_q  <= drop_err_d;
    end
  end

  assign cnt_out   = cnt_out_q;
  assign seq_no    = seq_no_q;
  assign cnt_valid = cnt_valid_q;
  assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_match_window_counter.sv
`timescale 1ns/1ps
module tb_match_window_counter;

  typedef struct {
    logic [7:0] cnt;
    logic [3:0] seq;
  } exp_t;

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t q_main[$];
  exp_t q_small[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // Default-parameter instance
  logic       en, bit_valid, match_in, cnt_ready, clr_err;
  logic [7:0] cnt_out;
  logic       cnt_valid;
  logic [3:0] seq_no;
  logic       drop_err;

  // WINDOW=4, CNT_W=2 instance for the saturation case
  logic       s_en, s_bit_valid, s_match_in, s_cnt_ready, s_clr_err;
  logic [1:0] s_cnt_out;
  logic       s_cnt_valid;
  logic [3:0] s_seq_no;
  logic       s_drop_err;

  match_window_counter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .bit_valid (bit_valid),
    .match_in  (match_in),
    .cnt_out   (cnt_out),
    .cnt_valid (cnt_valid),
    .cnt_ready (cnt_ready),
    .seq_no    (seq_no),
    .drop_err  (drop_err),
    .clr_err   (clr_err)
  );

  match_window_counter #(.WINDOW(4), .CNT_W(2)) dut_s (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (s_en),
    .bit_valid (s_bit_valid),
    .match_in  (s_match_in),
    .cnt_out   (s_cnt_out),
    .cnt_valid (s_cnt_valid),
    .cnt_ready (s_cnt_ready),
    .seq_no    (s_seq_no),
    .drop_err  (s_drop_err),
    .clr_err   (s_clr_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitors: a transfer happens at the next rising edge whenever valid and
  // ready are both high at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && cnt_valid && cnt_ready) begin
      if (q_main.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL main_unexpected: got cnt=%0d seq=%0d, required no result", cnt_out, seq_no);
      end else begin
        e = q_main.pop_front();
        chk("main_cnt", {24'd0, cnt_out}, {24'd0, e.cnt});
        chk("main_seq", {28'd0, seq_no}, {28'd0, e.seq});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && s_cnt_valid && s_cnt_ready) begin
      if (q_small.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL small_unexpected: got cnt=%0d seq=%0d, required no result", s_cnt_out, s_seq_no);
      end else begin
        e = q_small.pop_front();
        chk("small_cnt", {30'd0, s_cnt_out}, {24'd0, e.cnt});
        chk("small_seq", {28'd0, s_seq_no}, {28'd0, e.seq});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bit_valid = 1'b0;
    match_in  = 1'b0;
  endtask

  task automatic send_bit(input logic m);
    bit_valid = 1'b1;
    match_in  = m;
    tick();
  endtask

  task automatic send_bits(input logic [15:0] mv, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_bit(mv[i]);
  endtask

  task automatic push_main(input logic [7:0] c, input logic [3:0] s);
    exp_t e;
    e.cnt = c;
    e.seq = s;
    q_main.push_back(e);
  endtask

  task automatic push_small(input logic [7:0] c, input logic [3:0] s);
    exp_t e;
    e.cnt = c;
    e.seq = s;
    q_small.push_back(e);
  endtask

  // Assert reset between clock edges and check the outputs clear at once.
  task automatic pulse_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    chk({tag, "_rst_valid"}, {31'd0, cnt_valid}, 32'd0);
    chk({tag, "_rst_cnt"},   {24'd0, cnt_out},   32'd0);
    chk({tag, "_rst_seq"},   {28'd0, seq_no},    32'd0);
    chk({tag, "_rst_drop"},  {31'd0, drop_err},  32'd0);
    q_main.delete();
    en        = 1'b0;
    cnt_ready = 1'b0;
    clr_err   = 1'b0;
    idle();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1, "watchdog");
  end

  logic [15:0] v;

  initial begin
    reset_n     = 1'b0;
    en          = 1'b0;
    bit_valid   = 1'b0;
    match_in    = 1'b0;
    cnt_ready   = 1'b0;
    clr_err     = 1'b0;
    s_en        = 1'b0;
    s_bit_valid = 1'b0;
    s_match_in  = 1'b0;
    s_cnt_ready = 1'b0;
    s_clr_err   = 1'b0;
    tick();
    tick();
    chk("reset_valid", {31'd0, cnt_valid}, 32'd0);
    chk("reset_cnt",   {24'd0, cnt_out},   32'd0);
    chk("reset_seq",   {28'd0, seq_no},    32'd0);
    chk("reset_drop",  {31'd0, drop_err},  32'd0);
    reset_n = 1'b1;
    tick();

    // Test 1: detector output for bit stream 1010..., detector fresh at each
    // window start: matches on bits 2,4,...,14 -> 7 per window.
    v = 16'h5554;
    en = 1'b1;
    cnt_ready = 1'b1;
    tick();
    push_main(8'd7, 4'd1);
    send_bits(v, 0, 14);
    chk("t1_valid_before_last", {31'd0, cnt_valid}, 32'd0);
    send_bit(v[15]);
    chk("t1_valid_latency", {31'd0, cnt_valid}, 32'd1);
    chk("t1_cnt", {24'd0, cnt_out}, 32'd7);
    chk("t1_seq", {28'd0, seq_no}, 32'd1);
    push_main(8'd7, 4'd2);
    send_bits(v, 0, 15);
    chk("t1_cnt2", {24'd0, cnt_out}, 32'd7);
    chk("t1_seq2", {28'd0, seq_no}, 32'd2);
    idle();
    tick();
    tick();
    chk("t1_drained", q_main.size(), 32'd0);

    // Test 2: WINDOW=4, CNT_W=2, all-ones saturates at 3; next window 2.
    s_en = 1'b1;
    s_cnt_ready = 1'b1;
    tick();
    push_small(8'd3, 4'd1);
    for (int i = 0; i < 4; i++) begin
      s_bit_valid = 1'b1;
      s_match_in  = 1'b1;
      tick();
    end
    chk("t2_sat_cnt", {30'd0, s_cnt_out}, 32'd3);
    push_small(8'd2, 4'd2);
    for (int i = 0; i < 4; i++) begin
      s_bit_valid = 1'b1;
      s_match_in  = (i % 2 == 0);
      tick();
    end
    s_bit_valid = 1'b0;
    s_match_in  = 1'b0;
    tick();
    tick();
    chk("t2_drained", q_small.size(), 32'd0);
    s_en = 1'b0;

    // Test 3: back-pressure across windows, drop flag and clear priority.
    pulse_reset("t3");
    en = 1'b1;
    tick();
    push_main(8'd16, 4'd1);
    send_bits(16'hFFFF, 0, 15);
    chk("t3_loaded", {31'd0, cnt_valid}, 32'd1);
    chk("t3_no_drop_yet", {31'd0, drop_err}, 32'd0);
    send_bits(16'h0007, 0, 15);
    chk("t3_drop_set", {31'd0, drop_err}, 32'd1);
    chk("t3_cnt_held", {24'd0, cnt_out}, 32'd16);
    chk("t3_seq_held", {28'd0, seq_no}, 32'd1);
    send_bits(16'h00F0, 0, 14);
    clr_err = 1'b1;
    send_bit(1'b0);
    clr_err = 1'b0;
    chk("t3_set_wins", {31'd0, drop_err}, 32'd1);
    idle();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t3_cleared", {31'd0, drop_err}, 32'd0);
    cnt_ready = 1'b1;
    tick();
    chk("t3_accepted", {31'd0, cnt_valid}, 32'd0);
    push_main(8'd2, 4'd4);
    send_bits(16'h0101, 0, 15);
    idle();
    tick();
    tick();
    chk("t3_drained", q_main.size(), 32'd0);

    // Test 4: abort after 10 bits, re-enter; transition-cycle bit ignored.
    pulse_reset("t4");
    en = 1'b1;
    tick();
    send_bits(16'hFFFF, 0, 9);
    en = 1'b0;
    bit_valid = 1'b1;
    match_in  = 1'b1;
    tick();
    tick();
    tick();
    en = 1'b1;
    tick();
    chk("t4_no_result", {31'd0, cnt_valid}, 32'd0);
    v = 16'h8421;
    cnt_ready = 1'b1;
    push_main(8'd4, 4'd1);
    send_bits(v, 0, 14);
    chk("t4_valid_before_last", {31'd0, cnt_valid}, 32'd0);
    send_bit(v[15]);
    chk("t4_valid", {31'd0, cnt_valid}, 32'd1);
    idle();
    tick();
    tick();
    chk("t4_drained", q_main.size(), 32'd0);

    // Test 5: bit_valid every other cycle; match pulses on idle cycles.
    pulse_reset("t5");
    en = 1'b1;
    tick();
    v = 16'h1089;
    push_main(8'd4, 4'd1);
    for (int c = 0; c < 32; c++) begin
      if (c % 2 == 1) begin
        bit_valid = 1'b1;
        match_in  = v[c / 2];
      end else begin
        bit_valid = 1'b0;
        match_in  = 1'b1;
      end
      tick();
      if (c == 30) chk("t5_valid_at_31", {31'd0, cnt_valid}, 32'd0);
    end
    chk("t5_valid_at_32", {31'd0, cnt_valid}, 32'd1);
    idle();
    cnt_ready = 1'b1;
    tick();
    tick();
    chk("t5_drained", q_main.size(), 32'd0);

    // Test 6: async reset mid-window with a pending result.
    pulse_reset("t6a");
    en = 1'b1;
    tick();
    send_bits(16'hFFFF, 0, 15);
    chk("t6_pending", {31'd0, cnt_valid}, 32'd1);
    send_bits(16'hFFFF, 0, 7);
    pulse_reset("t6");
    en = 1'b1;
    cnt_ready = 1'b1;
    tick();
    v = 16'h0FF0;
    push_main(8'd8, 4'd1);
    send_bits(v, 0, 14);
    chk("t6_full_window", {31'd0, cnt_valid}, 32'd0);
    send_bit(v[15]);
    chk("t6_valid", {31'd0, cnt_valid}, 32'd1);
    chk("t6_drop_clear", {31'd0, drop_err}, 32'd0);
    idle();
    tick();
    tick();
    chk("t6_drained", q_main.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
